// File: rtl/fwd_hazard_unit_if.sv
// Purpose: groups the hazard unit's control, EX/ID operand and result signals.
// Latency: none, wiring only.
// Backpressure: none; id_stall is the unit's only hold signal toward the pipeline.
interface fwd_hazard_unit_if #(
  parameter int AW      = 5,
  parameter int NUM_SRC = 2,
  parameter int SW      = 2,
  parameter int CNT_W   = 16
);
  logic                  flush;
  logic                  fwd_en;
  logic                  ex_valid;
  logic                  ex_regwrite;
  logic                  ex_is_load;
  logic [AW-1:0]         ex_rd;
  logic [NUM_SRC*AW-1:0] ex_src;
  logic                  id_valid;
  logic [NUM_SRC*AW-1:0] id_src;
  logic [NUM_SRC*SW-1:0] fwd_sel;
  logic                  id_stall;
  logic [CNT_W-1:0]      stall_cnt;

  // Pipeline control side: drives instruction info, consumes selects and stall.
  modport master (
    output flush, fwd_en, ex_valid, ex_regwrite, ex_is_load, ex_rd, ex_src,
           id_valid, id_src,
    input  fwd_sel, id_stall, stall_cnt
  );

  // Hazard unit side.
  modport slave (
    input  flush, fwd_en, ex_valid, ex_regwrite, ex_is_load, ex_rd, ex_src,
           id_valid, id_src,
    output fwd_sel, id_stall, stall_cnt
  );
endinterface

// File: rtl/fwd_hazard_unit.sv
// Purpose: forwarding-select and load-use stall generation from a tracker of in-flight destinations.
// Latency: fwd_sel/id_stall are combinational in the same cycle; the tracker shifts one edge later.
// Backpressure: id_stall holds ID/IF (EX gets a bubble); the unit itself never waits.
module fwd_hazard_unit #(
  parameter int AW         = 5,
  parameter int NUM_SRC    = 2,
  parameter int FWD_STAGES = 2,
  parameter int LOAD_STAGE = 2,
  parameter int CNT_W      = 16,
  parameter int SW         = $clog2(FWD_STAGES + 1)
) (
  input  logic               clk,
  input  logic               rst_n,
  fwd_hazard_unit_if.slave   hz_if
);

  // Tracker entry k holds the instruction that was in EX k cycles ago.
  logic [FWD_STAGES:1] v_q, v_d;
  logic [FWD_STAGES:1] ld_q, ld_d;
  logic [AW-1:0]       rd_q [FWD_STAGES:1];
  logic [AW-1:0]       rd_d [FWD_STAGES:1];
  logic [CNT_W-1:0]    cnt_q, cnt_d;

  // Producer view: position 0 is the live EX instruction, 1..FWD_STAGES the tracker.
  logic [FWD_STAGES:0] pv;
  logic [FWD_STAGES:0] pld;
  logic [AW-1:0]       prd [FWD_STAGES:0];

  logic                  ex_writes;
  logic [NUM_SRC*SW-1:0] fwd_sel_c;
  logic                  stall_c;

  // r0 is hardwired zero, so a write to it never produces a forwardable value.
  assign ex_writes = hz_if.ex_valid & hz_if.ex_regwrite & (hz_if.ex_rd != '0);

  // Tracker next state: shift one stage per cycle, flush kills all valid bits.
  always_comb begin
    v_d  = '0;
    ld_d = '0;
    for (int k = 1; k <= FWD_STAGES; k++) begin
      rd_d[k] = '0;
    end
    v_d[1]  = ex_writes;
    ld_d[1] = hz_if.ex_is_load;
    rd_d[1] = hz_if.ex_rd;
    for (int k = 2; k <= FWD_STAGES; k++) begin
      v_d[k]  = v_q[k-1];
      ld_d[k] = ld_q[k-1];
      rd_d[k] = rd_q[k-1];
    end
    if (hz_if.flush) begin
      v_d = '0;
    end
  end

  // Tracker registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_q  <= '0;
      ld_q <= '0;
      for (int k = 1; k <= FWD_STAGES; k++) begin
        rd_q[k] <= '0;
      end
    end else begin
      v_q  <= v_d;
      ld_q <= ld_d;
      for (int k = 1; k <= FWD_STAGES; k++) begin
        rd_q[k] <= rd_d[k];
      end
    end
  end

  // Assemble the producer list used by the ID stall check.
  always_comb begin
    pv     = '0;
    pld    = '0;
    prd[0] = hz_if.ex_rd;
    pv[0]  = ex_writes;
    pld[0] = hz_if.ex_is_load;
    for (int k = 1; k <= FWD_STAGES; k++) begin
      pv[k]  = v_q[k];
      pld[k] = ld_q[k];
      prd[k] = rd_q[k];
    end
  end

  // EX forward select: scan oldest to youngest so the youngest match is kept last.
  // A load matched before LOAD_STAGE still selects its stage; the stall logic
  // guarantees that never happens when id_stall is honoured.
  always_comb begin
    fwd_sel_c = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (hz_if.fwd_en && (hz_if.ex_src[i*AW +: AW] != '0)) begin
        for (int k = FWD_STAGES; k >= 1; k--) begin
          if (v_q[k] && (rd_q[k] == hz_if.ex_src[i*AW +: AW])) begin
            fwd_sel_c[i*SW +: SW] = SW'(k);
          end
        end
      end
    end
  end

  // ID stall: with forwarding only too-young loads stall; without it every
  // producer short of the write stage stalls (the write stage writes through).
  always_comb begin
    stall_c = 1'b0;
    if (hz_if.id_valid && !hz_if.flush && rst_n) begin
      for (int i = 0; i < NUM_SRC; i++) begin
        if (hz_if.id_src[i*AW +: AW] != '0) begin
          for (int p = 0; p <= FWD_STAGES; p++) begin
            if (pv[p] && (prd[p] == hz_if.id_src[i*AW +: AW])) begin
              if (hz_if.fwd_en) begin
                if (pld[p] && (p < LOAD_STAGE - 1)) begin
                  stall_c = 1'b1;
                end
              end else if (p < FWD_STAGES) begin
                stall_c = 1'b1;
              end
            end
          end
        end
      end
    end
  end

  // Stall counter next state: saturates at all-ones, unaffected by flush.
  always_comb begin
    cnt_d = cnt_q;
    if (stall_c && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Stall counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign hz_if.fwd_sel   = fwd_sel_c;
  assign hz_if.id_stall  = stall_c;
  assign hz_if.stall_cnt = cnt_q;

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Bench for fwd_hazard_unit: default config plus a 3-stage/3-operand config with a
// 4-bit counter, both fed the same stream and checked against a history-list model.
module tb_fwd_hazard_unit;

  logic clk;
  logic rst_n;

  fwd_hazard_unit_if #(.AW(5), .NUM_SRC(2), .SW(2), .CNT_W(16)) ia ();
  fwd_hazard_unit_if #(.AW(5), .NUM_SRC(3), .SW(2), .CNT_W(4))  ib ();

  fwd_hazard_unit #(.AW(5), .NUM_SRC(2), .FWD_STAGES(2), .LOAD_STAGE(2), .CNT_W(16)) dut_a (
    .clk   (clk),
    .rst_n (rst_n),
    .hz_if (ia)
  );

  fwd_hazard_unit #(.AW(5), .NUM_SRC(3), .FWD_STAGES(3), .LOAD_STAGE(3), .CNT_W(4)) dut_b (
    .clk   (clk),
    .rst_n (rst_n),
    .hz_if (ib)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [5:0]  sel;
    logic        stall;
    logic [15:0] cnt;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];
  exp_t ea, eb;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: per config, history of what EX held 1..N cycles ago.
  bit         m_w  [2][4];
  logic [4:0] m_rd [2][4];
  bit         m_ld [2][4];
  int         m_cnt[2];
  bit         prev_stall[2];

  // Inputs that were applied during the cycle ending at the next edge.
  logic       p_fl, p_ev, p_ew, p_el;
  logic [4:0] p_erd;

  function automatic int fs(int c);
    return (c == 0) ? 2 : 3;
  endfunction
  function automatic int ls(int c);
    return (c == 0) ? 2 : 3;
  endfunction
  function automatic int ns(int c);
    return (c == 0) ? 2 : 3;
  endfunction
  function automatic int cmax(int c);
    return (c == 0) ? 65535 : 15;
  endfunction

  function automatic logic [14:0] pk(int a, int b, int c);
    return {5'(c), 5'(b), 5'(a)};
  endfunction

  function automatic int rr();
    return int'($urandom_range(0, 7));
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    vectors++;
    if (act !== expv) begin
      miscompares++;
      $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, expv);
    end
  endtask

  task automatic model_clear();
    for (int c = 0; c < 2; c++) begin
      for (int k = 0; k < 4; k++) begin
        m_w[c][k]  = 1'b0;
        m_rd[c][k] = '0;
        m_ld[c][k] = 1'b0;
      end
      m_cnt[c]      = 0;
      prev_stall[c] = 1'b0;
    end
  endtask

  // One cycle: retire the last edge into the model, drive new inputs, queue expectations.
  task automatic step(input logic rn, input logic fl, input logic fe,
                      input logic ev, input logic ew, input logic el, input logic [4:0] erd,
                      input logic [14:0] es, input logic iv, input logic [14:0] is);
    exp_t e;
    int s;
    logic hit, ld;
    @(posedge clk);
    #1;
    for (int c = 0; c < 2; c++) begin
      if (rst_n) begin
        if (prev_stall[c] && m_cnt[c] < cmax(c)) m_cnt[c]++;
        for (int k = fs(c); k >= 2; k--) begin
          m_w[c][k]  = m_w[c][k-1];
          m_rd[c][k] = m_rd[c][k-1];
          m_ld[c][k] = m_ld[c][k-1];
        end
        m_w[c][1]  = p_ev && p_ew && (p_erd != 0);
        m_rd[c][1] = p_erd;
        m_ld[c][1] = p_el;
        if (p_fl) for (int k = 1; k <= 3; k++) m_w[c][k] = 1'b0;
      end
    end

    ia.flush = fl; ib.flush = fl;
    ia.fwd_en = fe; ib.fwd_en = fe;
    ia.ex_valid = ev; ib.ex_valid = ev;
    ia.ex_regwrite = ew; ib.ex_regwrite = ew;
    ia.ex_is_load = el; ib.ex_is_load = el;
    ia.ex_rd = erd; ib.ex_rd = erd;
    ia.ex_src = es[9:0]; ib.ex_src = es;
    ia.id_valid = iv; ib.id_valid = iv;
    ia.id_src = is[9:0]; ib.id_src = is;
    rst_n = rn;
    if (!rn) model_clear();

    for (int c = 0; c < 2; c++) begin
      e.sel = '0;
      e.stall = 1'b0;
      for (int i = 0; i < ns(c); i++) begin
        s = 0;
        if (fe && es[i*5 +: 5] != 0) begin
          for (int k = 1; k <= fs(c); k++) begin
            if (m_w[c][k] && m_rd[c][k] == es[i*5 +: 5]) begin
              s = k;
              break;
            end
          end
        end
        e.sel[i*2 +: 2] = 2'(s);
        if (rn && !fl && iv && is[i*5 +: 5] != 0) begin
          for (int p = 0; p <= fs(c); p++) begin
            if (p == 0) begin
              hit = ev && ew && (erd != 0) && (erd == is[i*5 +: 5]);
              ld  = el;
            end else begin
              hit = m_w[c][p] && (m_rd[c][p] == is[i*5 +: 5]);
              ld  = m_ld[c][p];
            end
            if (hit && (fe ? (ld && p < ls(c) - 1) : (p < fs(c)))) e.stall = 1'b1;
          end
        end
      end
      e.cnt = 16'(m_cnt[c]);
      prev_stall[c] = e.stall;
      if (c == 0) qa.push_back(e);
      else qb.push_back(e);
    end

    p_fl = fl; p_ev = ev; p_ew = ew; p_el = el; p_erd = erd;
  endtask

  // Monitor: outputs are presented every cycle; compare mid-cycle.
  always @(negedge clk) begin
    if (qa.size() > 0) begin
      ea = qa.pop_front();
      chk("a_fwd_sel",   32'(ia.fwd_sel),   32'(ea.sel[3:0]));
      chk("a_id_stall",  32'(ia.id_stall),  32'(ea.stall));
      chk("a_stall_cnt", 32'(ia.stall_cnt), 32'(ea.cnt));
    end
    if (qb.size() > 0) begin
      eb = qb.pop_front();
      chk("b_fwd_sel",   32'(ib.fwd_sel),   32'(eb.sel));
      chk("b_id_stall",  32'(ib.id_stall),  32'(eb.stall));
      chk("b_stall_cnt", 32'(ib.stall_cnt), 32'(eb.cnt[3:0]));
    end
  end

  initial begin
    logic rn, fe, fe_mode;
    rst_n = 1'b0;
    p_fl = 0; p_ev = 0; p_ew = 0; p_el = 0; p_erd = '0;
    ia.flush = 0; ia.fwd_en = 1; ia.ex_valid = 0; ia.ex_regwrite = 0; ia.ex_is_load = 0;
    ia.ex_rd = '0; ia.ex_src = '0; ia.id_valid = 0; ia.id_src = '0;
    ib.flush = 0; ib.fwd_en = 1; ib.ex_valid = 0; ib.ex_regwrite = 0; ib.ex_is_load = 0;
    ib.ex_rd = '0; ib.ex_src = '0; ib.id_valid = 0; ib.id_src = '0;
    model_clear();

    // Held in reset with hazards presented: everything must read zero.
    repeat (3) step(0, 0, 1, 1, 1, 1, 5'd3, pk(3, 3, 3), 1, pk(3, 3, 3));

    // add r3, then readers at distance 1, 2, 3.
    step(1, 0, 1, 1, 1, 0, 5'd3, pk(0, 0, 0), 0, pk(0, 0, 0));
    repeat (3) step(1, 0, 1, 0, 0, 0, 5'd0, pk(3, 3, 3), 0, pk(0, 0, 0));

    // load r5 with dependent in ID, bubble, then consumer in EX.
    step(1, 0, 1, 1, 1, 1, 5'd5, pk(0, 0, 0), 1, pk(5, 0, 0));
    step(1, 0, 1, 0, 0, 0, 5'd0, pk(0, 0, 0), 1, pk(5, 0, 0));
    step(1, 0, 1, 1, 1, 0, 5'd9, pk(5, 0, 0), 0, pk(0, 0, 0));

    // Two writers of r7 in flight, then r0 writer/reader.
    step(1, 0, 1, 1, 1, 0, 5'd7, pk(0, 0, 0), 0, pk(0, 0, 0));
    step(1, 0, 1, 1, 1, 0, 5'd7, pk(0, 0, 0), 0, pk(0, 0, 0));
    step(1, 0, 1, 1, 1, 0, 5'd0, pk(7, 7, 7), 1, pk(0, 0, 0));
    step(1, 0, 1, 0, 0, 0, 5'd0, pk(0, 0, 0), 1, pk(0, 0, 0));

    // Stall-only mode: add r4 with r4 reader held in ID until the write stage.
    step(1, 0, 0, 1, 1, 0, 5'd4, pk(0, 0, 0), 1, pk(0, 4, 0));
    step(1, 0, 0, 0, 0, 0, 5'd0, pk(0, 0, 0), 1, pk(0, 4, 0));
    step(1, 0, 0, 0, 0, 0, 5'd0, pk(0, 0, 0), 1, pk(0, 4, 0));
    step(1, 0, 0, 1, 1, 0, 5'd8, pk(0, 4, 0), 0, pk(0, 0, 0));

    // Load r9 feeding operand 2 of the 3-operand config.
    step(1, 0, 1, 1, 1, 1, 5'd9, pk(0, 0, 0), 1, pk(0, 0, 9));
    step(1, 0, 1, 0, 0, 0, 5'd0, pk(0, 0, 0), 1, pk(0, 0, 9));
    step(1, 0, 1, 0, 0, 0, 5'd0, pk(0, 0, 0), 1, pk(0, 0, 9));
    step(1, 0, 1, 1, 1, 0, 5'd1, pk(0, 0, 9), 0, pk(0, 0, 0));

    // Load r5, then flush with hazards presented, then check the tracker is empty.
    step(1, 0, 1, 1, 1, 1, 5'd5, pk(0, 0, 0), 0, pk(0, 0, 0));
    step(1, 1, 1, 0, 0, 0, 5'd0, pk(5, 5, 5), 1, pk(5, 5, 5));
    step(1, 0, 1, 0, 0, 0, 5'd0, pk(5, 5, 5), 1, pk(5, 5, 5));

    // Randomized traffic with mode phases, flushes and occasional mid-stream resets.
    fe_mode = 1'b1;
    for (int n = 0; n < 4000; n++) begin
      if (n % 64 == 0) fe_mode = 1'($urandom_range(0, 2) != 0);
      fe = fe_mode ? 1'($urandom_range(0, 15) != 0) : 1'($urandom_range(0, 15) == 0);
      if (rst_n) rn = 1'($urandom_range(0, 249) != 0);
      else rn = 1'($urandom_range(0, 1));
      step(rn, 1'($urandom_range(0, 24) == 0), fe,
           1'($urandom_range(0, 4) != 0), 1'($urandom_range(0, 4) != 0),
           1'($urandom_range(0, 2) == 0), 5'(rr()),
           pk(rr(), rr(), rr()), 1'($urandom_range(0, 4) != 0), pk(rr(), rr(), rr()));
    end

    @(negedge clk);
    #1;
    chk("scoreboard_drain", 32'(qa.size() + qb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/fwd_hazard_unit.md
Name: fwd_hazard_unit

Overview:
- Parametrised forwarding and load-use hazard unit for the pipelined datapath; successor to the fixed two-stage, two-operand forwarding logic.
- Keeps its own shift register of destination tags for instructions in flight past EX. Produces per-operand forward selects for EX and a stall request for ID.
- Supports configurable forwarding depth, operand count and load latency, a runtime forwarding-disable (stall-only) mode, pipeline flush and a saturating stall counter.

Parameters:
- AW, 5, register address width.
- NUM_SRC, 2, source operands per instruction.
- FWD_STAGES, 2, tracked stages after EX (stage 1 = EX/MEM … stage FWD_STAGES = MEM/WB, the register-file write stage).
- LOAD_STAGE, 2, first tracked stage whose load result can be forwarded; range 1..FWD_STAGES.
- CNT_W, 16, stall counter width.
- Derived: SW = $clog2(FWD_STAGES+1).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- flush  in  1  synchronous; invalidates all tracked stages.
- fwd_en  in  1  1 = forwarding mode; 0 = stall-only mode.
- ex_valid  in  1  instruction in EX is valid (not a bubble).
- ex_regwrite  in  1  EX instruction writes rd.
- ex_is_load  in  1  EX instruction is a load.
- ex_rd  in  AW  EX destination register.
- ex_src  in  NUM_SRC*AW  EX source registers; operand i in bits [i*AW +: AW].
- id_valid  in  1  instruction in ID is valid.
- id_src  in  NUM_SRC*AW  ID source registers, packed the same way.
- fwd_sel  out  NUM_SRC*SW  per EX operand: 0 = register file, k = tracked stage k.
- id_stall  out  1  hold PC and IF/ID; the pipeline inserts a bubble into EX.
- stall_cnt  out  CNT_W  cycles with id_stall=1, saturating.

Behaviour:
- Tracker: entries t[1..FWD_STAGES], each holding {v, rd, ld}.
  - Every rising edge: t[1] <= {ex_valid & ex_regwrite & (ex_rd!=0), ex_rd, ex_is_load}; t[k] <= t[k-1] for k ≥ 2.
  - flush=1: all v <= 0 at that edge, overriding the shift.
  - rst_n=0: all v, rd, ld = 0 immediately.
- fwd_sel, combinational, per operand i:
  - fwd_en=0 or ex_src[i]==0: value is 0.
  - Otherwise: the smallest k with t[k].v and t[k].rd==ex_src[i] (youngest producer wins); 0 if there is no match.
  - A matched t[k].ld with k<LOAD_STAGE still selects k. This cannot occur when id_stall is honoured.
- Producer positions: p=0 is the current EX instruction (valid only if ex_valid & ex_regwrite & ex_rd!=0); p=k is t[k].
- id_stall, combinational; asserted when id_valid and any operand with id_src[i]!=0 matches a valid producer at position p where:
  - fwd_en=1: producer is a load and p < LOAD_STAGE-1.
  - fwd_en=0: p < FWD_STAGES. The write stage writes through the register file, so a match at p=FWD_STAGES does not stall.
  - id_stall is forced 0 while flush=1 or rst_n=0.
- stall_cnt increments on each edge where id_stall=1 and holds at 2^CNT_W-1. Reset clears it to 0; flush does not clear it.
- Reset values: t[*]=0, stall_cnt=0, fwd_sel=0, id_stall=0.
- Latency: fwd_sel and id_stall are same-cycle combinational outputs. Tracker updates take effect one edge later.
- fwd_en may change on any cycle; it takes effect immediately with no state change.
- Reset mid-operation clears everything asynchronously. The first edge after release shifts normally.

Test Plan:
- Defaults; EX: add r3 (valid, regwrite). Next cycle EX ex_src={r3,r3} → fwd_sel={1,1}. One cycle later a fresh EX reading r3 → fwd_sel=2. One more cycle → fwd_sel=0.
- Load r5 in EX while ID has id_src[0]=r5 → id_stall=1 for exactly 1 cycle; stall_cnt=1. Consumer then reaches EX → fwd_sel[0]=2, id_stall=0.
- Writes to r7 in t[1] and t[2] simultaneously, EX reads r7 → fwd_sel=1 (youngest wins). Writer with rd=r0, or reader of r0 → fwd_sel=0, id_stall=0.
- fwd_en=0, add r4 in EX, ID reads r4 → id_stall=1 for 2 cycles (p=0, then p=1), released at p=2; stall_cnt=2. fwd_sel stays 0 throughout.
- FWD_STAGES=3, LOAD_STAGE=3, NUM_SRC=3: load r9 then ID reads r9 in operand 2 → 2 stall cycles, then fwd_sel[2]=3.
- Load r5 in t[1], then flush=1 for one edge → all t.v=0, id_stall=0 that cycle, stall_cnt unchanged. Then rst_n pulsed low mid-stream → stall_cnt=0, outputs 0 asynchronously.
